iic_slave: RTL and testbench

I2C target (slave) controller, the responder end of the team's `IIC_CORE` master. It decodes START/STOP, matches a 7-bit device address, and receives a 1- or 2-byte register pointer. It then moves data bytes between the bus and a simple synchronous register-file port. The block sits between the SDA/SCL pads (open-drain, tri-state via `sda_oe`) and on-chip configuration registers.

---
 rtl/iic_pkg.sv | 27 ++
 rtl/iic_in_filter.sv | 50 +++++
 rtl/iic_slave.sv | 154 +++++++++++++++
 tb/tb_iic_slave.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK levels and pointer helpers.
// Used by iic_slave and by the IIC_CORE master.
package iic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEV_ADDR  = 3'd1,
    ST_REG_ADDR  = 3'd2,
    ST_WR_DATA   = 3'd3,
    ST_RD_DATA   = 3'd4,
    ST_WAIT_STOP = 3'd5
  } iic_state_e;

  localparam logic IIC_ACK  = 1'b0;
  localparam logic IIC_NACK = 1'b1;

  localparam int IIC_BIT_CNT_W = 4;

  // Pointer increment that wraps at 2^(8*nbytes); nbytes is 1 or 2.
  function automatic logic [15:0] ptr_inc(input logic [15:0] p, input int nbytes);
    logic [15:0] r;
    if (nbytes == 1) r = {8'h00, p[7:0] + 8'd1};
    else             r = p + 16'd1;
    return r;
  endfunction

endpackage

// File: rtl/iic_in_filter.sv
// Pad conditioning for one I2C line: 2-FF synchronizer, FILT_LEN-sample
// equality filter (FILT_LEN >= 2) and registered rise/fall pulses.
module iic_in_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic line_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0]          sync_q;
  logic [FILT_LEN-2:0] hist_q;
  logic [FILT_LEN-1:0] win;
  logic                out_q;
  logic                rise_q;
  logic                fall_q;

  // Window includes the freshest synchronized sample so pad-to-edge is 2+FILT_LEN.
  assign win = {hist_q, sync_q[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= '1;
      out_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      hist_q <= win[FILT_LEN-2:0];
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if ((&win) && !out_q) begin
        out_q  <= 1'b1;
        rise_q <= 1'b1;
      end else if (!(|win) && out_q) begin
        out_q  <= 1'b0;
        fall_q <= 1'b1;
      end
    end
  end

  assign line_o = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/iic_slave.sv
// I2C target: START/STOP decode, 7-bit address match, 1/2-byte register
// pointer and a synchronous register-file port. SDA is open-drain via sda_oe.
module iic_slave #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         ADDR_BYTES = 1,
  parameter int         FILT_LEN   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_oe,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy,
  output logic        stop_det,
  output logic [2:0]  dbg_state_o
);
  import iic_pkg::*;

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_c, stop_c;

  iic_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst_n(rst_n), .line_i(scl_i),
    .line_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  iic_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst_n(rst_n), .line_i(sda_i),
    .line_o(sda_s), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start_c = sda_fall & scl_s;
  assign stop_c  = sda_rise & scl_s;

  iic_state_e               state_q, state_d;
  logic [IIC_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                     ack_ph_q, ack_ph_d;
  logic [7:0]               rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d;
  logic [15:0]              ptr_q, ptr_d;
  logic                     idx_q, idx_d, rd_q, rd_d, oe_q, oe_d;
  logic                     we_q, we_d, re_q, re_d, busy_q, busy_d, stop_q, stop_d;
  logic                     load_q;
  logic [7:0]               rx_byte;

  assign rx_byte = {rx_q[6:0], sda_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;  bit_cnt_q <= '0;    ack_ph_q <= 1'b0;
      rx_q    <= '0;       tx_q      <= '0;    wdata_q  <= '0;
      ptr_q   <= '0;       idx_q     <= 1'b0;  rd_q     <= 1'b0;
      oe_q    <= 1'b0;     we_q      <= 1'b0;  re_q     <= 1'b0;
      busy_q  <= 1'b0;     stop_q    <= 1'b0;  load_q   <= 1'b0;
    end else begin
      state_q <= state_d;  bit_cnt_q <= bit_cnt_d; ack_ph_q <= ack_ph_d;
      rx_q    <= rx_d;     tx_q      <= tx_d;      wdata_q  <= wdata_d;
      ptr_q   <= ptr_d;    idx_q     <= idx_d;     rd_q     <= rd_d;
      oe_q    <= oe_d;     we_q      <= we_d;      re_q     <= re_d;
      busy_q  <= busy_d;   stop_q    <= stop_d;    load_q   <= re_q;
    end
  end

  always_comb begin
    state_d = state_q;  bit_cnt_d = bit_cnt_q; ack_ph_d = ack_ph_q;
    rx_d    = rx_q;     tx_d      = tx_q;      wdata_d  = wdata_q;
    ptr_d   = ptr_q;    idx_d     = idx_q;     rd_d     = rd_q;
    oe_d    = oe_q;     we_d      = 1'b0;      re_d     = 1'b0;
    busy_d  = busy_q;   stop_d    = 1'b0;
    // Bus conditions win over any SCL edge seen in the same cycle.
    if (stop_c) begin
      state_d = ST_IDLE; oe_d = 1'b0; busy_d = 1'b0; stop_d = 1'b1;
      bit_cnt_d = '0; ack_ph_d = 1'b0;
    end else if (start_c) begin
      state_d = ST_DEV_ADDR; oe_d = 1'b0; bit_cnt_d = '0; ack_ph_d = 1'b0;
    end else if (state_q inside {ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA, ST_RD_DATA}) begin
      if (scl_rise) begin
        if (!ack_ph_q) begin
          if (bit_cnt_q != 4'd8) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (bit_cnt_q == 4'd7) begin
            case (state_q)
              ST_DEV_ADDR: begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  busy_d = 1'b1; rd_d = rx_byte[0]; re_d = rx_byte[0];
                end else begin
                  state_d = ST_WAIT_STOP;
                end
              end
              ST_REG_ADDR: ptr_d = (ADDR_BYTES == 1) ? {8'h00, rx_byte} : {ptr_q[7:0], rx_byte};
              ST_WR_DATA: begin
                wdata_d = rx_byte; we_d = 1'b1;
              end
              default: ;
            endcase
          end
        end else if (state_q == ST_RD_DATA) begin
          if (sda_s == IIC_ACK) begin
            ptr_d = ptr_inc(ptr_q, ADDR_BYTES); re_d = 1'b1;
          end else begin
            state_d = ST_WAIT_STOP;
          end
        end
      end else if (scl_fall) begin
        if (!ack_ph_q && bit_cnt_q == 4'd8) begin
          // Enter the ACK slot: we ACK our own bytes, the master ACKs read bytes.
          ack_ph_d = 1'b1;
          oe_d     = (state_q != ST_RD_DATA);
        end else if (ack_ph_q) begin
          ack_ph_d = 1'b0; bit_cnt_d = '0; oe_d = 1'b0;
          case (state_q)
            ST_DEV_ADDR: begin
              if (rd_q) begin
                state_d = ST_RD_DATA; oe_d = ~tx_q[7];
              end else begin
                state_d = ST_REG_ADDR; idx_d = 1'b0;
              end
            end
            ST_REG_ADDR: begin
              if (int'(idx_q) == ADDR_BYTES - 1) state_d = ST_WR_DATA;
              else                               idx_d   = 1'b1;
            end
            ST_WR_DATA: ptr_d = ptr_inc(ptr_q, ADDR_BYTES);
            ST_RD_DATA: oe_d = ~tx_q[7];
            default: ;
          endcase
        end else if (state_q == ST_RD_DATA && bit_cnt_q != '0) begin
          tx_d = {tx_q[6:0], 1'b0};
          oe_d = ~tx_q[6];
        end
      end
    end
    if (load_q) tx_d = reg_rdata;
  end

  assign sda_o       = 1'b0;
  assign sda_oe      = oe_q;
  assign reg_addr    = ptr_q;
  assign reg_wdata   = wdata_q;
  assign reg_we      = we_q;
  assign reg_re      = re_q;
  assign busy        = busy_q;
  assign stop_det    = stop_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iic_slave.sv
// Directed bench for iic_slave: an open-drain bus master drives two targets
// (0x50 with 1-byte pointer, 0x51 with 2-byte pointer); writes are scoreboarded.
module tb_iic_slave;

  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic m_scl = 1'b1, m_sda = 1'b1, sel = 1'b0;
  logic line1, line2, line;

  logic        oe1, so1, we1, re1, busy1, stop1;
  logic [15:0] addr1;
  logic [7:0]  wdata1, rdata1;
  logic [2:0]  st1;
  logic        oe2, so2, we2, re2, busy2, stop2;
  logic [15:0] addr2;
  logic [7:0]  wdata2, rdata2;
  logic [2:0]  st2;

  assign line1 = m_sda & ~oe1;
  assign line2 = m_sda & ~oe2;
  assign line  = sel ? line2 : line1;

  iic_slave #(.DEV_ADDR(7'h50), .ADDR_BYTES(1), .FILT_LEN(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .scl_i(m_scl), .sda_i(line1), .sda_o(so1), .sda_oe(oe1),
    .reg_addr(addr1), .reg_wdata(wdata1), .reg_we(we1), .reg_re(re1), .reg_rdata(rdata1),
    .busy(busy1), .stop_det(stop1), .dbg_state_o(st1)
  );

  iic_slave #(.DEV_ADDR(7'h51), .ADDR_BYTES(2), .FILT_LEN(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .scl_i(m_scl), .sda_i(line2), .sda_o(so2), .sda_oe(oe2),
    .reg_addr(addr2), .reg_wdata(wdata2), .reg_we(we2), .reg_re(re2), .reg_rdata(rdata2),
    .busy(busy2), .stop_det(stop2), .dbg_state_o(st2)
  );

  // Register file model behind dut1: data valid the cycle after reg_re.
  logic [7:0] mem [256];
  always @(posedge clk) if (re1) rdata1 <= mem[addr1[7:0]];
  initial rdata2 = 8'h00;

  int n_vec = 0;
  int n_err = 0;
  int re_cnt1 = 0, stop_cnt1 = 0;
  logic oe_seen1 = 1'b0;
  logic [23:0] exp1_q[$];
  logic [23:0] exp2_q[$];
  logic [23:0] e1, e2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we1) begin
      if (exp1_q.size() == 0) check("we1_unexpected", 32'(we1), 32'd0);
      else begin
        e1 = exp1_q.pop_front();
        check("we1_addr_data", {8'h00, addr1, wdata1}, {8'h00, e1});
      end
    end
    if (we2) begin
      if (exp2_q.size() == 0) check("we2_unexpected", 32'(we2), 32'd0);
      else begin
        e2 = exp2_q.pop_front();
        check("we2_addr_data", {8'h00, addr2, wdata2}, {8'h00, e2});
      end
    end
    if (re1)   re_cnt1++;
    if (stop1) stop_cnt1++;
    if (oe1)   oe_seen1 = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    tick(Q); m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(2 * Q);
  endtask

  task automatic write_bit(input logic b, input logic spike);
    tick(Q);
    m_sda = b;
    if (spike) begin
      tick(3); m_scl = 1'b1; tick(1); m_scl = 1'b0; tick(Q - 4);
    end else begin
      tick(Q);
    end
    m_scl = 1'b1; tick(2 * Q); m_scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    tick(Q); m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); b = line; tick(Q); m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, input int spike_bit, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i], (i == spike_bit));
    read_bit(b);
    acked = ~b;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~ack, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         rc, sc;
    logic [7:0] v;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33; mem[8'h31] = 8'h6C;
    rdata1 = 8'h00;

    tick(4);
    check("rst_sda_oe",   32'(oe1),    32'd0);
    check("rst_sda_o",    32'(so1),    32'd0);
    check("rst_reg_we",   32'(we1),    32'd0);
    check("rst_reg_re",   32'(re1),    32'd0);
    check("rst_wdata",    32'(wdata1), 32'd0);
    check("rst_reg_addr", 32'(addr1),  32'd0);
    check("rst_busy",     32'(busy1),  32'd0);
    check("rst_stop_det", 32'(stop1),  32'd0);
    check("rst_state",    32'(st1),    32'd0);
    rst_n = 1'b1;
    tick(10);

    // Write 0x12 <- A5, 3C
    exp1_q.push_back({16'h0012, 8'hA5});
    exp1_q.push_back({16'h0013, 8'h3C});
    bus_start();
    write_byte(8'hA0, -1, ack); check("wr_ack_dev",  32'(ack), 32'd1);
    write_byte(8'h12, -1, ack); check("wr_ack_reg",  32'(ack), 32'd1);
    write_byte(8'hA5, -1, ack); check("wr_ack_d0",   32'(ack), 32'd1);
    write_byte(8'h3C, -1, ack); check("wr_ack_d1",   32'(ack), 32'd1);
    check("wr_busy", 32'(busy1), 32'd1);
    sc = stop_cnt1;
    bus_stop();
    check("wr_stop_det", 32'(stop_cnt1 - sc), 32'd1);
    check("wr_busy_end", 32'(busy1), 32'd0);
    check("wr_ptr_after", 32'(addr1), 32'h14);
    check("wr_all_seen", 32'(exp1_q.size()), 32'd0);

    // Random read from 0x20 via repeated START
    rc = re_cnt1;
    bus_start();
    write_byte(8'hA0, -1, ack); check("rd_ack_devw", 32'(ack), 32'd1);
    write_byte(8'h20, -1, ack); check("rd_ack_reg",  32'(ack), 32'd1);
    bus_start();
    write_byte(8'hA1, -1, ack); check("rd_ack_devr", 32'(ack), 32'd1);
    read_byte(1'b1, d); check("rd_byte0", 32'(d), 32'h11);
    read_byte(1'b1, d); check("rd_byte1", 32'(d), 32'h22);
    read_byte(1'b0, d); check("rd_byte2", 32'(d), 32'h33);
    check("rd_wait_stop", 32'(st1), 32'd5);
    bus_stop();
    check("rd_re_count", 32'(re_cnt1 - rc), 32'd3);
    check("rd_ptr_after", 32'(addr1), 32'h22);

    // Address mismatch on dut1 (0x51 belongs to dut2)
    oe_seen1 = 1'b0;
    rc = re_cnt1;
    bus_start();
    write_byte(8'hA2, -1, ack); check("mm_no_ack", 32'(ack), 32'd0);
    check("mm_busy", 32'(busy1), 32'd0);
    bus_stop();
    check("mm_oe_never", 32'(oe_seen1), 32'd0);
    check("mm_no_re", 32'(re_cnt1 - rc), 32'd0);
    check("mm_state", 32'(st1), 32'd0);

    // Pointer wrap on the 2-byte-pointer target
    sel = 1'b1;
    exp2_q.push_back({16'hFFFF, 8'h77});
    exp2_q.push_back({16'h0000, 8'h88});
    bus_start();
    write_byte(8'hA2, -1, ack); check("wrap_ack_dev", 32'(ack), 32'd1);
    write_byte(8'hFF, -1, ack); check("wrap_ack_msb", 32'(ack), 32'd1);
    write_byte(8'hFF, -1, ack); check("wrap_ack_lsb", 32'(ack), 32'd1);
    write_byte(8'h77, -1, ack); check("wrap_ack_d0",  32'(ack), 32'd1);
    write_byte(8'h88, -1, ack); check("wrap_ack_d1",  32'(ack), 32'd1);
    bus_stop();
    check("wrap_ptr_after", 32'(addr2), 32'h0001);
    check("wrap_all_seen", 32'(exp2_q.size()), 32'd0);
    sel = 1'b0;

    // SCL glitch inside a data byte
    exp1_q.push_back({16'h0030, 8'h5A});
    bus_start();
    write_byte(8'hA0, -1, ack); check("gl_ack_dev", 32'(ack), 32'd1);
    write_byte(8'h30, -1, ack); check("gl_ack_reg", 32'(ack), 32'd1);
    write_byte(8'h5A,  3, ack); check("gl_ack_d0",  32'(ack), 32'd1);
    bus_stop();
    check("gl_all_seen", 32'(exp1_q.size()), 32'd0);
    check("gl_ptr_after", 32'(addr1), 32'h31);

    // Read with retained pointer (0x31)
    rc = re_cnt1;
    bus_start();
    write_byte(8'hA1, -1, ack); check("ret_ack_dev", 32'(ack), 32'd1);
    read_byte(1'b0, d); check("ret_byte", 32'(d), 32'h6C);
    bus_stop();
    check("ret_re_count", 32'(re_cnt1 - rc), 32'd1);

    // STOP in the middle of a data byte
    sc = stop_cnt1;
    bus_start();
    write_byte(8'hA0, -1, ack); check("ab_ack_dev", 32'(ack), 32'd1);
    write_byte(8'h40, -1, ack); check("ab_ack_reg", 32'(ack), 32'd1);
    write_bit(1'b1, 1'b0); write_bit(1'b0, 1'b0); write_bit(1'b1, 1'b0); write_bit(1'b0, 1'b0);
    bus_stop();
    check("ab_stop_det", 32'(stop_cnt1 - sc), 32'd1);
    check("ab_state", 32'(st1), 32'd0);
    check("ab_oe", 32'(oe1), 32'd0);
    check("ab_busy", 32'(busy1), 32'd0);

    // Reset while dut1 drives the ACK slot
    bus_start();
    write_byte(8'hA0, -1, ack); check("rs_ack_dev", 32'(ack), 32'd1);
    v = 8'h41;
    for (int i = 7; i >= 0; i--) write_bit(v[i], 1'b0);
    tick(Q);
    check("rs_ack_driven", 32'(oe1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rs_oe_async", 32'(oe1), 32'd0);
    check("rs_state", 32'(st1), 32'd0);
    check("rs_ptr", 32'(addr1), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(10);
    bus_stop();
    check("rs_state_end", 32'(st1), 32'd0);
    check("rs_no_we", 32'(exp1_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    n_vec++;
    n_err++;
    $display("FAIL watchdog: got timeout expected end of sequence");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
